// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control blocks: FSM state encoding, watchdog width and the
// branch command used by both hazard detection and the stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} pipe_state_t;

    localparam int unsigned WDOG_W = 8;

    typedef enum logic [1:0] {BR_NONE, BR_TAKEN, BR_PENDING} brcmd_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline control bundle: hazard/branch/memory status in, per-stage freeze/bubble/flush
// controls and stall statistics out. The controller sits on the slave modport.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_freeze;
    logic             ifid_freeze;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_freeze;
    logic             memwb_bubble;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output hazard_detected, branch_taken, mem_req, mem_ready,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, memwb_bubble,
        input  stall_timeout, stall_cycles, flush_cycles
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_req, mem_ready,
        output pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, memwb_bubble,
        output stall_timeout, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/pipe_perf_counter.sv
// Free-running wrapping event counter with asynchronous active-high reset.
module pipe_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline freeze/bubble/flush sequencer with sticky hazard-stall watchdog.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 15,
    parameter int unsigned CNT_W        = 32
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam logic [2:0]        FlushLoad  = 3'(FLUSH_CYCLES - 1);
    localparam logic              FlushMulti = (FLUSH_CYCLES > 1);
    localparam logic [WDOG_W-1:0] WdogMax    = WDOG_W'(MAX_STALL);

    pipe_state_t       state_d, state_q;
    logic [2:0]        fcnt_d, fcnt_q;
    logic              pend_d, pend_q;
    logic [WDOG_W-1:0] wdog_d, wdog_q;
    logic              timeout_d, timeout_q;

    brcmd_t br_cmd;
    logic   mem_stall, hz_stall;
    logic   pc_frz, ifid_frz, ifid_fl, idex_bub, exmem_frz, memwb_bub;

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pend_d    = pend_q;
        br_cmd    = BR_NONE;
        hz_stall  = 1'b0;
        pc_frz    = 1'b0;
        ifid_frz  = 1'b0;
        ifid_fl   = 1'b0;
        idex_bub  = 1'b0;
        exmem_frz = 1'b0;
        memwb_bub = 1'b0;
        mem_stall = bus.mem_req && !bus.mem_ready;

        // Outputs are gated by rst so an asserted reset silences them without waiting for a clock.
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.branch_taken) br_cmd = BR_TAKEN;
                    else if (pend_q)      br_cmd = BR_PENDING;
                    if (mem_stall) begin
                        {pc_frz, ifid_frz, exmem_frz, memwb_bub} = 4'b1111;
                        pend_d  = (br_cmd != BR_NONE);
                        state_d = ST_MEM_WAIT;
                    end else if (br_cmd != BR_NONE) begin
                        ifid_fl  = 1'b1;
                        idex_bub = 1'b1;
                        fcnt_d   = FlushLoad;
                        pend_d   = 1'b0;
                        state_d  = FlushMulti ? ST_FLUSH : ST_RUN;
                    end else if (bus.hazard_detected) begin
                        {pc_frz, ifid_frz, idex_bub} = 3'b111;
                        hz_stall = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.branch_taken) pend_d = 1'b1;
                    if (!bus.mem_ready) {pc_frz, ifid_frz, exmem_frz, memwb_bub} = 4'b1111;
                    else                state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    // Preempting memory wait drops the partial flush; pending replays it in full.
                    if (mem_stall) begin
                        {pc_frz, ifid_frz, exmem_frz, memwb_bub} = 4'b1111;
                        pend_d  = 1'b1;
                        state_d = ST_MEM_WAIT;
                    end else begin
                        ifid_fl = 1'b1;
                        if (bus.branch_taken) begin
                            fcnt_d = FlushLoad;
                        end else begin
                            fcnt_d = fcnt_q - 3'd1;
                            if (fcnt_q <= 3'd1) state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        wdog_d = '0;
        if (hz_stall) wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
        timeout_d = timeout_q | (hz_stall && (wdog_d >= WdogMax));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            fcnt_q    <= '0;
            pend_q    <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pend_q    <= pend_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_freeze     = pc_frz;
    assign bus.ifid_freeze   = ifid_frz;
    assign bus.ifid_flush    = ifid_fl;
    assign bus.idex_bubble   = idex_bub;
    assign bus.exmem_freeze  = exmem_frz;
    assign bus.memwb_bubble  = memwb_bub;
    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (pc_frz),
        .count_o (stall_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ifid_fl),
        .count_o (flush_cnt)
    );

    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_cycles = flush_cnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central pipeline control block. Consumes the ID-stage hazard flag, the EXE-stage branch-taken flag and the data-memory wait signal.
- Produces the freeze, bubble and flush controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Sequences multi-cycle memory waits and branch flushes with a registered FSM.
- Guards against livelock with a sticky stall watchdog.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a taken branch (1..7).
- MAX_STALL, 15: consecutive hazard-stall cycles before the watchdog trips (1..255).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_detected  in  1  ID data hazard from hazard detection, same cycle.
- branch_taken  in  1  EXE resolved taken branch, one-cycle pulse.
- mem_req  in  1  MEM stage issuing a load or store this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_freeze  out  1  hold PC.
- ifid_freeze  out  1  hold IF/ID register.
- ifid_flush  out  1  zero IF/ID (NOP).
- idex_bubble  out  1  load NOP into ID/EXE.
- exmem_freeze  out  1  hold EXE/MEM and ID/EXE.
- memwb_bubble  out  1  load NOP into MEM/WB.
- stall_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  count of hazard-stall cycles.
- flush_cycles  out  CNT_W  count of flush cycles.

Behaviour:
- FSM states are RUN, MEM_WAIT and FLUSH. The state register is reset asynchronously to RUN.
- Control outputs are combinational from state and inputs, so a hazard stalls in the same cycle it is flagged. stall_timeout and the counters are registered.
- On reset, all outputs are 0, the flush counter is 0 and the watchdog counter is 0.
- Priority within a cycle: memory wait > branch flush > hazard stall.
- RUN:
  - mem_req=1 with mem_ready=0: assert pc_freeze, ifid_freeze, exmem_freeze and memwb_bubble this cycle; next state MEM_WAIT.
  - mem_req=1 with mem_ready=1: no stall; stay in RUN.
  - Otherwise, branch_taken=1: assert ifid_flush and idex_bubble this cycle. Load the flush counter with FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
  - Otherwise, hazard_detected=1: assert pc_freeze, ifid_freeze and idex_bubble.
- MEM_WAIT:
  - Same freeze set as on entry while mem_ready=0.
  - mem_ready=1: deassert all freezes that cycle; return to RUN.
  - A branch_taken pulse arriving during MEM_WAIT is held in a pending bit. It is honoured in the first RUN cycle, behaving as branch_taken=1.
  - hazard_detected is ignored in MEM_WAIT.
- FLUSH:
  - Assert ifid_flush every cycle; decrement the counter.
  - Return to RUN when the counter is 0.
  - A new branch_taken in FLUSH reloads the counter.
  - mem_req with mem_ready=0 in FLUSH preempts to MEM_WAIT. The remaining flush is dropped and a branch pending bit is set, so the flush restarts in full afterwards.
  - hazard_detected is ignored in FLUSH; the flushed instruction is not real.
- Watchdog:
  - An 8-bit counter increments on each cycle that hazard_detected causes a stall.
  - It clears on any cycle without a hazard stall.
  - When it reaches MAX_STALL, stall_timeout sets and stays set until rst. Stalling continues; the watchdog does not break the stall.
- Counters:
  - stall_cycles increments on each cycle pc_freeze=1.
  - flush_cycles increments on each cycle ifid_flush=1.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-stall or mid-flush drops every output to 0 immediately (asynchronous) and discards pending state.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cycles and flush_cycles are implemented as specified.
- PIPE_PERF_CNT_EN undefined: no counter flops; both ports are tied to 0. Port list is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} pipe_state_t;
  - constant WDOG_W=8;
  - brcmd_t, moved into the package so hazard detection and this block share it.
- One sub-module, pipe_perf_counter: a CNT_W-bit saturating-off, wrapping enable counter with async reset. It is instantiated twice, inside the PIPE_PERF_CNT_EN guard.

Test Plan:
- hazard_detected=1 for 2 cycles in RUN -> pc_freeze, ifid_freeze and idex_bubble high in exactly those 2 cycles, same-cycle; stall_cycles=2.
- branch_taken pulse with FLUSH_CYCLES=3 -> ifid_flush high 3 cycles, idex_bubble high in the first cycle only; flush_cycles=3; state back to RUN.
- mem_req=1, mem_ready low 4 cycles then high -> exmem_freeze and memwb_bubble high 4 cycles, low in the mem_ready cycle. A branch_taken during the wait -> ifid_flush in the first cycle after.
- branch_taken and hazard_detected in the same cycle -> ifid_flush=1, pc_freeze=0.
- hazard_detected held 20 cycles with MAX_STALL=15 -> stall_timeout rises after 15 stall cycles and stays high after hazard_detected drops until rst.
- rst asserted mid-MEM_WAIT -> all outputs 0 immediately, asynchronously; after release, state RUN and counters 0.
